// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, port identifiers
// and a port-to-one-hot helper used for the grant and done pulses.
package dmem_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    logic [1:0] oh;
    if (port == PORT_DBG) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester always wins; on a conflict
// the port that was not granted last wins. Pointer moves only when advance is high.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt_onehot
);

  logic       last_r;
  logic [1:0] gnt_s;

  // Winner selection from the current requests and the last-granted pointer
  always_comb begin
    gnt_s = 2'b00;
    case (req)
      2'b01:   gnt_s = 2'b01;
      2'b10:   gnt_s = 2'b10;
      2'b11: begin
        if (last_r == PORT_CORE) begin
          gnt_s = 2'b10;
        end else begin
          gnt_s = 2'b01;
        end
      end
      default: gnt_s = 2'b00;
    endcase
  end

  // Last-granted pointer; reset value makes port 0 win the first conflict
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= PORT_DBG;
    end else if (advance && (gnt_s != 2'b00)) begin
      last_r <= gnt_s[1];
    end
  end

  assign gnt_onehot = gnt_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the pipeline MEM stage (port 0)
// and a debug/DMA loader (port 1); one access at a time, MEM_LAT cycles each.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  arb_state_e        state_r;
  arb_state_e        state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              port_r;
  logic              we_r;
  logic [1:0]        arb_gnt_s;
  logic [1:0]        gnt_r;
  logic [1:0]        done_r;
  logic              grant_s;
  logic              grant_port_s;
  logic              next_port_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic              stall_r;
  logic              stall_s;

  rr_arbiter2 u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        ({m1_req, m0_req}),
    .advance    (state_r == ST_IDLE),
    .gnt_onehot (arb_gnt_s)
  );

  // Grant qualification and selection of the winning port's transaction
  always_comb begin
    grant_s      = (state_r == ST_IDLE) && (arb_gnt_s != 2'b00);
    grant_port_s = arb_gnt_s[1];
    if (grant_port_s == PORT_DBG) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
  end

  // Next-state logic: leave IDLE on any grant, return once the counter expires
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Stall: port 0 waiting on the request line, or owning the access next cycle;
  // the request line is ignored while port 0's own access is finishing
  always_comb begin
    if (state_r == ST_IDLE) begin
      next_port_s = grant_port_s;
    end else begin
      next_port_s = port_r;
    end
    stall_s = ((state_s == ST_ACCESS) && (next_port_s == PORT_CORE)) ||
              (m0_req && !((state_r == ST_ACCESS) && (port_r == PORT_CORE)));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Transaction latch, latency counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= CNT_ZERO;
      port_r      <= PORT_CORE;
      we_r        <= 1'b0;
      gnt_r       <= 2'b00;
      done_r      <= 2'b00;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      rdata0_r    <= {DATA_W{1'b0}};
      rdata1_r    <= {DATA_W{1'b0}};
      stall_r     <= 1'b0;
    end else begin
      gnt_r       <= 2'b00;
      done_r      <= 2'b00;
      mem_write_r <= 1'b0;
      stall_r     <= stall_s;
      case (state_r)
        ST_IDLE: begin
          if (grant_s) begin
            port_r      <= grant_port_s;
            we_r        <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_write_r <= sel_we_s;
            mem_read_r  <= ~sel_we_s;
            cnt_r       <= CNT_LOAD;
            gnt_r       <= port_onehot(grant_port_s);
          end else begin
            mem_read_r  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (cnt_r == CNT_ZERO) begin
            mem_read_r <= 1'b0;
            done_r     <= port_onehot(port_r);
            // Read data is captured in the last access cycle; writes leave rdata alone
            if (!we_r && (port_r == PORT_DBG)) begin
              rdata1_r <= mem_rdata;
            end else if (!we_r) begin
              rdata0_r <= mem_rdata;
            end
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          mem_read_r <= 1'b0;
        end
      endcase
    end
  end

  assign m0_gnt     = gnt_r[0];
  assign m1_gnt     = gnt_r[1];
  assign m0_done    = done_r[0];
  assign m1_done    = done_r[1];
  assign m0_rdata   = rdata0_r;
  assign m1_rdata   = rdata1_r;
  assign core_stall = stall_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW     = 64;
  localparam int DW     = 64;
  localparam int LAT_A  = 1;
  localparam int N_RAND = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_m0_req, a_m0_we, a_m0_gnt, a_m0_done;
  logic [AW-1:0] a_m0_addr;
  logic [DW-1:0] a_m0_wdata, a_m0_rdata;
  logic          a_m1_req, a_m1_we, a_m1_gnt, a_m1_done;
  logic [AW-1:0] a_m1_addr;
  logic [DW-1:0] a_m1_wdata, a_m1_rdata;
  logic          a_core_stall, a_mem_read, a_mem_write;
  logic [AW-1:0] a_mem_addr;
  logic [DW-1:0] a_mem_wdata, a_mem_rdata;

  logic          b_m0_req, b_m0_we, b_m0_gnt, b_m0_done;
  logic [AW-1:0] b_m0_addr;
  logic [DW-1:0] b_m0_wdata, b_m0_rdata;
  logic          b_m1_req, b_m1_we, b_m1_gnt, b_m1_done;
  logic [AW-1:0] b_m1_addr;
  logic [DW-1:0] b_m1_wdata, b_m1_rdata;
  logic          b_core_stall, b_mem_read, b_mem_write;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] b_mem_wdata, b_mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst(rst),
    .m0_req(a_m0_req), .m0_we(a_m0_we), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
    .m0_gnt(a_m0_gnt), .m0_done(a_m0_done), .m0_rdata(a_m0_rdata),
    .m1_req(a_m1_req), .m1_we(a_m1_we), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
    .m1_gnt(a_m1_gnt), .m1_done(a_m1_done), .m1_rdata(a_m1_rdata),
    .core_stall(a_core_stall), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .mem_rdata(a_mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_gnt(b_m0_gnt), .m0_done(b_m0_done), .m0_rdata(b_m0_rdata),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
    .m1_gnt(b_m1_gnt), .m1_done(b_m1_done), .m1_rdata(b_m1_rdata),
    .core_stall(b_core_stall), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_rdata(b_mem_rdata)
  );

  function automatic logic [DW-1:0] mem_init(input logic [7:0] a);
    if (a == 8'h20) return 64'h55;
    return 64'hC0DE_0000_0000_0000 | {56'h0, a};
  endfunction

  // Memories behind each DUT: combinational read, reloaded on reset
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  assign a_mem_rdata = mem_a[a_mem_addr[7:0]];
  assign b_mem_rdata = mem_b[b_mem_addr[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= mem_init(8'(i));
    end else if (a_mem_write) begin
      mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= mem_init(8'(i));
    end else if (b_mem_write) begin
      mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference-model state for the randomized run
  logic [DW-1:0] ref_mem [256];
  bit            exp_g  [2][N_RAND+8];
  bit            exp_d  [2][N_RAND+8];
  bit            exp_mw [N_RAND+8];
  bit            exp_mr [N_RAND+8];
  bit            exp_b0 [N_RAND+8];
  logic [7:0]    exp_ad [N_RAND+8];
  logic [DW-1:0] exp_wd [N_RAND+8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_m0_req = 1'b0; a_m0_we = 1'b0; a_m0_addr = '0; a_m0_wdata = '0;
    a_m1_req = 1'b0; a_m1_we = 1'b0; a_m1_addr = '0; a_m1_wdata = '0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    a_m0_req = 1'b1; a_m1_req = 1'b1; b_m0_req = 1'b1; b_m1_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done, a_mem_read, a_mem_write, a_core_stall} !== 7'b0)
        begin errors++; $display("FAIL reset_ctl_a: got %b want 0", {a_m0_gnt, a_m1_gnt, a_m0_done, a_m1_done, a_mem_read, a_mem_write, a_core_stall}); end
      checks++;
      if ((a_mem_addr | a_mem_wdata | a_m0_rdata | a_m1_rdata) !== 64'h0)
        begin errors++; $display("FAIL reset_data_a: got %0h want 0", a_mem_addr | a_mem_wdata | a_m0_rdata | a_m1_rdata); end
      checks++;
      if ({b_m0_gnt, b_m1_gnt, b_m0_done, b_m1_done, b_mem_read, b_mem_write, b_core_stall} !== 7'b0)
        begin errors++; $display("FAIL reset_ctl_b: got %b want 0", {b_m0_gnt, b_m1_gnt, b_m0_done, b_m1_done, b_mem_read, b_mem_write, b_core_stall}); end
    end
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if ({a_m0_gnt, a_m1_gnt, a_mem_write} !== 3'b0)
      begin errors++; $display("FAIL reset_release: got %b want 0", {a_m0_gnt, a_m1_gnt, a_mem_write}); end
  endtask

  task automatic test_write_read;
    do_reset();
    a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 64'h10; a_m0_wdata = 64'hDEAD;
    tick();
    checks++;
    if ({a_m0_gnt, a_mem_write, a_mem_read, a_core_stall} !== 4'b1101)
      begin errors++; $display("FAIL wr_grant: got %b want 1101", {a_m0_gnt, a_mem_write, a_mem_read, a_core_stall}); end
    checks++;
    if ({a_mem_addr, a_mem_wdata} !== {64'h10, 64'hDEAD})
      begin errors++; $display("FAIL wr_bus: got %0h/%0h want 10/dead", a_mem_addr, a_mem_wdata); end
    a_m0_req = 1'b0;
    tick();
    checks++;
    if ({a_m0_done, a_m0_gnt, a_mem_write, a_core_stall} !== 4'b1000)
      begin errors++; $display("FAIL wr_done: got %b want 1000", {a_m0_done, a_m0_gnt, a_mem_write, a_core_stall}); end
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 64'h10;
    tick();
    checks++;
    if ({a_m0_gnt, a_mem_read, a_mem_write} !== 3'b110)
      begin errors++; $display("FAIL rd_grant: got %b want 110", {a_m0_gnt, a_mem_read, a_mem_write}); end
    a_m0_req = 1'b0;
    tick();
    checks++;
    if ({a_m0_done, a_m0_rdata} !== {1'b1, 64'hDEAD})
      begin errors++; $display("FAIL rd_data: got %b/%0h want 1/dead", a_m0_done, a_m0_rdata); end
  endtask

  task automatic test_round_robin;
    int ng;
    int gp [4];
    int gt [4];
    ng = 0;
    for (int i = 0; i < 4; i++) begin gp[i] = -1; gt[i] = -1; end
    do_reset();
    a_m0_req = 1'b1; a_m0_addr = 64'h1;
    a_m1_req = 1'b1; a_m1_addr = 64'h2;
    for (int c = 1; c <= 40 && ng < 4; c++) begin
      tick();
      if (a_m0_gnt || a_m1_gnt) begin
        gp[ng] = a_m1_gnt ? 1 : 0;
        gt[ng] = c;
        ng++;
      end
      a_m0_req = !a_m0_gnt;
      a_m1_req = !a_m1_gnt;
      if (ng == 4) begin a_m0_req = 1'b0; a_m1_req = 1'b0; end
    end
    checks++;
    if (ng !== 4) begin errors++; $display("FAIL rr_count: got %0d want 4", ng); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gp[i] !== i % 2) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gp[i], i % 2); end
      checks++;
      if (gt[i] !== 1 + 2 * i) begin errors++; $display("FAIL rr_time[%0d]: got %0d want %0d", i, gt[i], 1 + 2 * i); end
    end
    tick();
    tick();
    checks++;
    if ({a_m0_rdata, a_m1_rdata} !== {mem_init(8'h01), mem_init(8'h02)})
      begin errors++; $display("FAIL rr_rdata: got %0h/%0h want %0h/%0h", a_m0_rdata, a_m1_rdata, mem_init(8'h01), mem_init(8'h02)); end
  endtask

  task automatic test_latency3;
    int nrd;
    int tdone;
    nrd = 0;
    tdone = -1;
    do_reset();
    b_m1_req = 1'b1; b_m1_we = 1'b0; b_m1_addr = 64'h20;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) begin
        checks++;
        if ({b_m1_gnt, b_mem_read, b_mem_addr} !== {2'b11, 64'h20})
          begin errors++; $display("FAIL lat3_grant: got %b%b/%0h want 11/20", b_m1_gnt, b_mem_read, b_mem_addr); end
      end
      if (b_m1_gnt) b_m1_req = 1'b0;
      if (b_mem_read) nrd++;
      if (b_m1_done && tdone < 0) tdone = c;
    end
    checks++;
    if (nrd !== 3) begin errors++; $display("FAIL lat3_read_cycles: got %0d want 3", nrd); end
    checks++;
    if (tdone !== 4) begin errors++; $display("FAIL lat3_done_time: got %0d want 4", tdone); end
    checks++;
    if (b_m1_rdata !== 64'h55) begin errors++; $display("FAIL lat3_rdata: got %0h want 55", b_m1_rdata); end
  endtask

  task automatic test_stall;
    do_reset();
    a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 64'h3;
    tick();
    checks++;
    if ({a_m1_gnt, a_core_stall} !== 2'b10)
      begin errors++; $display("FAIL stall_m1_gnt: got %b want 10", {a_m1_gnt, a_core_stall}); end
    a_m1_req = 1'b0;
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 64'h4;
    tick();
    checks++;
    if ({a_m1_done, a_core_stall, a_m0_gnt} !== 3'b110)
      begin errors++; $display("FAIL stall_waiting: got %b want 110", {a_m1_done, a_core_stall, a_m0_gnt}); end
    tick();
    checks++;
    if ({a_m0_gnt, a_core_stall} !== 2'b11)
      begin errors++; $display("FAIL stall_m0_gnt: got %b want 11", {a_m0_gnt, a_core_stall}); end
    a_m0_req = 1'b0;
    tick();
    checks++;
    if ({a_m0_done, a_core_stall, a_m0_rdata} !== {2'b10, mem_init(8'h04)})
      begin errors++; $display("FAIL stall_m0_done: got %b%b/%0h want 10/%0h", a_m0_done, a_core_stall, a_m0_rdata, mem_init(8'h04)); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 64'h30; a_m0_wdata = 64'hBEEF;
    tick();
    checks++;
    if ({a_m0_gnt, a_mem_write} !== 2'b11)
      begin errors++; $display("FAIL rstmid_grant: got %b want 11", {a_m0_gnt, a_mem_write}); end
    rst = 1'b1;
    a_m0_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      rst = 1'b0;
      checks++;
      if ({a_mem_write, a_m0_done, a_m0_gnt, a_mem_read} !== 4'b0)
        begin errors++; $display("FAIL rstmid_quiet[%0d]: got %b want 0000", i, {a_mem_write, a_m0_done, a_m0_gnt, a_mem_read}); end
    end
    a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 64'h30;
    tick();
    checks++;
    if (a_m0_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b want 1", a_m0_gnt); end
    a_m0_req = 1'b0;
    tick();
    checks++;
    if (a_m0_rdata !== mem_init(8'h30)) begin errors++; $display("FAIL rstmid_rdata: got %0h want %0h", a_m0_rdata, mem_init(8'h30)); end
  endtask

  task automatic test_random;
    logic          rq [2];
    logic          rwe [2];
    logic [7:0]    rad [2];
    logic [DW-1:0] rwd [2];
    logic [DW-1:0] cur_rd [2];
    logic [DW-1:0] pend_val [2];
    logic          pend_rd [2];
    int            free_at;
    int            last;
    int            w;
    logic          req0_prev;
    logic          busy_prev;
    logic          stall_e;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(8'(i));
    for (int i = 0; i < N_RAND + 8; i++) begin
      exp_g[0][i] = 1'b0; exp_g[1][i] = 1'b0; exp_d[0][i] = 1'b0; exp_d[1][i] = 1'b0;
      exp_mw[i] = 1'b0; exp_mr[i] = 1'b0; exp_b0[i] = 1'b0; exp_ad[i] = 8'h0; exp_wd[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      rq[p] = 1'b0; rwe[p] = 1'b0; rad[p] = 8'h0; rwd[p] = '0;
      cur_rd[p] = '0; pend_val[p] = '0; pend_rd[p] = 1'b0;
    end
    free_at = 0;
    last = 1;
    req0_prev = 1'b0;
    for (int c = 0; c < N_RAND; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (exp_d[p][c] && pend_rd[p]) cur_rd[p] = pend_val[p];
      end
      busy_prev = (c > 0) ? exp_b0[c-1] : 1'b0;
      stall_e = exp_b0[c] | (req0_prev & ~busy_prev);
      checks++;
      if ({a_m1_gnt, a_m0_gnt, a_m1_done, a_m0_done} !== {exp_g[1][c], exp_g[0][c], exp_d[1][c], exp_d[0][c]})
        begin errors++; $display("FAIL rand_gnt_done c=%0d: got %b want %b", c, {a_m1_gnt, a_m0_gnt, a_m1_done, a_m0_done}, {exp_g[1][c], exp_g[0][c], exp_d[1][c], exp_d[0][c]}); end
      checks++;
      if ({a_mem_write, a_mem_read, a_core_stall} !== {exp_mw[c], exp_mr[c], stall_e})
        begin errors++; $display("FAIL rand_mem_stall c=%0d: got %b want %b", c, {a_mem_write, a_mem_read, a_core_stall}, {exp_mw[c], exp_mr[c], stall_e}); end
      checks++;
      if ({a_m0_rdata, a_m1_rdata} !== {cur_rd[0], cur_rd[1]})
        begin errors++; $display("FAIL rand_rdata c=%0d: got %0h/%0h want %0h/%0h", c, a_m0_rdata, a_m1_rdata, cur_rd[0], cur_rd[1]); end
      if (exp_mw[c] || exp_mr[c]) begin
        checks++;
        if (a_mem_addr !== {56'h0, exp_ad[c]})
          begin errors++; $display("FAIL rand_addr c=%0d: got %0h want %0h", c, a_mem_addr, exp_ad[c]); end
      end
      if (exp_mw[c]) begin
        checks++;
        if (a_mem_wdata !== exp_wd[c])
          begin errors++; $display("FAIL rand_wdata c=%0d: got %0h want %0h", c, a_mem_wdata, exp_wd[c]); end
      end
      // requester agents: drop after grant, occasionally withdraw, randomly start
      for (int p = 0; p < 2; p++) begin
        if (exp_g[p][c]) begin
          rq[p] = 1'b0;
        end else if (rq[p]) begin
          if ($urandom_range(0, 15) == 0) rq[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rq[p] = 1'b1;
          rwe[p] = 1'($urandom_range(0, 1));
          rad[p] = 8'($urandom_range(0, 15));
          rwd[p] = {$urandom, $urandom};
        end
      end
      a_m0_req = rq[0]; a_m0_we = rwe[0]; a_m0_addr = {56'h0, rad[0]}; a_m0_wdata = rwd[0];
      a_m1_req = rq[1]; a_m1_we = rwe[1]; a_m1_addr = {56'h0, rad[1]}; a_m1_wdata = rwd[1];
      // reference: memory free from the done cycle on; conflicts go to the other port
      if (c >= free_at && (rq[0] || rq[1])) begin
        if (rq[0] && rq[1]) w = (last == 0) ? 1 : 0;
        else if (rq[1]) w = 1;
        else w = 0;
        last = w;
        exp_g[w][c+1] = 1'b1;
        exp_d[w][c+1+LAT_A] = 1'b1;
        free_at = c + 1 + LAT_A;
        for (int k = 0; k < LAT_A; k++) begin
          exp_b0[c+1+k] = (w == 0);
          exp_ad[c+1+k] = rad[w];
          if (!rwe[w]) exp_mr[c+1+k] = 1'b1;
        end
        if (rwe[w]) begin
          exp_mw[c+1] = 1'b1;
          exp_wd[c+1] = rwd[w];
          ref_mem[rad[w]] = rwd[w];
          pend_rd[w] = 1'b0;
        end else begin
          pend_rd[w] = 1'b1;
          pend_val[w] = ref_mem[rad[w]];
        end
      end
      req0_prev = rq[0];
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_latency3();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
